// File: rtl/press_decoder.sv
// Groups debounced press pulses into single/double/triple-tap commands and
// presents each command over a valid/ready handshake; presses during a pending command are dropped.
module press_decoder #(
  parameter int unsigned WINDOW   = 1000000,
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned MAX_TAPS = 3
) (
  input  logic       Myclk,
  input  logic       rst_n,
  input  logic       press,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic       drop
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam logic [1:0]       TAPS_MAX   = 2'(MAX_TAPS);
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(WINDOW - 1);

  state_t           state, state_nx;
  logic [1:0]       taps, taps_nx, taps_inc;
  logic [CNT_W-1:0] timer, timer_nx;
  logic             valid_nx, drop_nx;
  logic [1:0]       code_nx;

  always_ff @(posedge Myclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      taps      <= '0;
      timer     <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      drop      <= 1'b0;
    end else begin
      state     <= state_nx;
      taps      <= taps_nx;
      timer     <= timer_nx;
      cmd_valid <= valid_nx;
      cmd_code  <= code_nx;
      drop      <= drop_nx;
    end
  end

  assign taps_inc = taps + 2'd1;

  always_comb begin
    state_nx = state;
    taps_nx  = taps;
    timer_nx = timer;
    drop_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          taps_nx  = 2'd1;
          timer_nx = '0;
          state_nx = (TAPS_MAX == 2'd1) ? EMIT : COLLECT;
        end
      end
      COLLECT: begin
        // A press on the timeout cycle takes priority over closing the burst.
        if (press) begin
          taps_nx  = taps_inc;
          timer_nx = '0;
          if (taps_inc == TAPS_MAX) state_nx = EMIT;
        end else if (timer == TIMER_LAST) begin
          state_nx = EMIT;
        end else begin
          timer_nx = timer + CNT_W'(1);
        end
      end
      EMIT: begin
        drop_nx = press;
        if (cmd_valid && cmd_ready) begin
          state_nx = IDLE;
          taps_nx  = '0;
          timer_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        taps_nx  = '0;
        timer_nx = '0;
      end
    endcase
    // Outputs are registered from the next-state view so they align with the state register.
    valid_nx = (state_nx == EMIT);
    code_nx  = valid_nx ? taps_nx : '0;
  end

endmodule

// File: tb/tb_press_decoder.sv
// Scoreboard bench for press_decoder: directed tap scenarios plus randomized press/ready/reset traffic
// compared cycle by cycle against a cycle-count based reference model.
`timescale 1ns/1ps
module tb_press_decoder;

  localparam int unsigned WINDOW   = 8;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned MAX_TAPS = 3;

  logic       Myclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       press = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       drop;

  press_decoder #(
    .WINDOW  (WINDOW),
    .CNT_W   (CNT_W),
    .MAX_TAPS(MAX_TAPS)
  ) dut (
    .Myclk    (Myclk),
    .rst_n    (rst_n),
    .press    (press),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .drop     (drop)
  );

  always #5 Myclk = ~Myclk;

  int cyc = 0;
  always @(posedge Myclk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: per-cycle output expectations and accepted-command codes.
  typedef struct {
    int cyc;
    bit v;
    int code;
    bit d;
  } exp_t;
  exp_t exp_q[$];
  int   cmd_q[$];

  // Reference model: a burst is a count of presses plus the cycle of the last one.
  bit m_burst, m_pend;
  int m_count, m_last, m_pcode;

  task automatic model_reset();
    m_burst = 0; m_pend = 0; m_count = 0; m_last = -1000; m_pcode = 0;
  endtask

  task automatic model_close();
    m_pend  = 1;
    m_pcode = m_count;
    m_burst = 0;
    cmd_q.push_back(m_count);
  endtask

  task automatic model_step(input bit p, input bit r);
    exp_t e;
    bit d;
    d = p && m_pend;
    if (m_pend) begin
      if (r) m_pend = 0;
    end else if (m_burst) begin
      if (p) begin
        m_count++;
        m_last = cyc;
        if (m_count == int'(MAX_TAPS)) model_close();
      end else if (cyc - m_last == int'(WINDOW)) begin
        model_close();
      end
    end else if (p) begin
      m_count = 1;
      m_last  = cyc;
      if (MAX_TAPS == 1) model_close();
      else m_burst = 1;
    end
    e.cyc  = cyc + 1;
    e.v    = m_pend;
    e.code = m_pend ? m_pcode : 0;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit p, input bit r);
    press     = p;
    cmd_ready = r;
    model_step(p, r);
  endtask

  // Monitor statistics relative to the start of a directed scenario.
  bit mon_on = 0;
  int base = 0;
  int first_rel, first_code, n_vc, n_drops, n_cmds, last_drop;

  task automatic stats_clear();
    base = cyc; first_rel = -1; first_code = -1; n_vc = 0; n_drops = 0; n_cmds = 0; last_drop = -1;
  endtask

  always @(negedge Myclk) begin
    if (mon_on) begin
      exp_t e;
      if (cmd_valid === 1'b1) begin
        n_vc++;
        if (first_rel < 0) begin
          first_rel  = cyc - base;
          first_code = int'(cmd_code);
        end
      end
      if (drop === 1'b1) begin
        n_drops++;
        last_drop = cyc - base;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("sb_stale_entry", 32'(e.cyc), 32'(cyc));
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check("cmd_valid", 32'(cmd_valid), 32'(e.v));
        check("cmd_code", 32'(cmd_code), 32'(e.code));
        check("drop", 32'(drop), 32'(e.d));
      end
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        n_cmds++;
        if (cmd_q.size() == 0) check("unexpected_cmd", 32'(cmd_code), 32'hFFFF_FFFF);
        else check("accepted_code", 32'(cmd_code), 32'(cmd_q.pop_front()));
      end
    end
  end

  // Called at posedge+1; asserts reset mid-cycle, holds it for n cycles, releases mid-cycle.
  task automatic do_reset(input int n);
    #2 rst_n = 1'b0;
    exp_q.delete();
    cmd_q.delete();
    model_reset();
    #1;
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_cmd_code", 32'(cmd_code), 0);
    check("rst_drop", 32'(drop), 0);
    repeat (n) begin
      @(posedge Myclk); #1;
      drive(0, 0);
    end
    #2 rst_n = 1'b1;
  endtask

  function automatic bit press_at(input int id, input int rel);
    case (id)
      0: return rel == 10;
      1: return rel == 10 || rel == 17;
      2: return rel == 10 || rel == 12 || rel == 14;
      3: return rel == 10 || rel == 18;
      4: return rel == 10 || rel == 22;
      default: return 0;
    endcase
  endfunction

  task automatic run_scn(input int id);
    @(posedge Myclk); #1;
    do_reset(2);
    for (int rel = 0; rel < 50; rel++) begin
      @(posedge Myclk); #1;
      if (rel == 0) stats_clear();
      drive(press_at(id, rel), (id == 4) ? (rel >= 30) : 1'b1);
    end
  endtask

  initial begin
    model_reset();
    stats_clear();
    repeat (3) @(posedge Myclk);
    #3 rst_n = 1'b1;
    mon_on = 1;

    run_scn(0);
    check("single_first", 32'(first_rel), 19);
    check("single_code", 32'(first_code), 1);
    check("single_valid_len", 32'(n_vc), 1);
    check("single_drops", 32'(n_drops), 0);

    run_scn(1);
    check("double_first", 32'(first_rel), 26);
    check("double_code", 32'(first_code), 2);
    check("double_cmds", 32'(n_cmds), 1);

    run_scn(2);
    check("triple_first", 32'(first_rel), 15);
    check("triple_code", 32'(first_code), 3);

    run_scn(3);
    check("collide_first", 32'(first_rel), 27);
    check("collide_code", 32'(first_code), 2);
    check("collide_cmds", 32'(n_cmds), 1);

    run_scn(4);
    check("bp_first", 32'(first_rel), 19);
    check("bp_code", 32'(first_code), 1);
    check("bp_valid_len", 32'(n_vc), 12);
    check("bp_drops", 32'(n_drops), 1);
    check("bp_drop_cycle", 32'(last_drop), 23);
    check("bp_cmds", 32'(n_cmds), 1);

    // Reset in the middle of a burst: presses at 10 and 12, reset during cycle 13.
    @(posedge Myclk); #1;
    do_reset(2);
    for (int rel = 0; rel <= 13; rel++) begin
      @(posedge Myclk); #1;
      if (rel == 0) stats_clear();
      drive(rel == 10 || rel == 12, 1'b1);
    end
    do_reset(2);
    repeat (55) begin
      @(posedge Myclk); #1;
      drive(0, 1);
    end
    check("rst_valid_cycles", 32'(n_vc), 0);
    check("rst_cmds", 32'(n_cmds), 0);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge Myclk); #1;
      if ($urandom_range(0, 299) == 0) begin
        do_reset(2);
      end else begin
        drive($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
      end
    end
    repeat (20) begin
      @(posedge Myclk); #1;
      drive(0, 1);
    end
    @(posedge Myclk); #1;
    check("cmd_queue_drained", 32'(cmd_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
